// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath widths used by the adder and subtractor
// pipelines and by the combinational adder they are built from.
package alu_pkg;

  localparam int ALU_HALF_W = 16;
  localparam int ALU_W      = 32;

endpackage : alu_pkg

// File: rtl/adderNbit.sv
// Combinational N-bit ripple adder with carry in/out. Used once per half-word
// by the pipelined adder and subtractor.
module adderNbit
  import alu_pkg::*;
#(
  parameter int N = ALU_HALF_W
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};

endmodule : adderNbit

// File: rtl/sub2etapas_hs.sv
// Pipelined M-bit subtractor d = a - b - bor_i, computed as a + ~b + ~bor_i.
// Low half is added in S1->S2, high half (using the registered low carry) in
// S2->S3. Each stage has a valid bit and advances under a valid/ready
// handshake so bubbles collapse and up to three results are held on a stall.
module sub2etapas_hs
  import alu_pkg::*;
#(
  parameter int N = ALU_HALF_W,
  parameter int M = ALU_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic         bor_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [M-1:0] d_o,
  output logic         bor_o,
  output logic         ovf_o,
  output logic         zero_o
);

  if (M != 2 * N) begin : g_width_check
    $error("sub2etapas_hs: M must equal 2*N");
  end

  // Stage 1: registered operands.
  logic         r_v1;
  logic [M-1:0] r_a1;
  logic [M-1:0] r_b1;
  logic         r_bor1;

  // Stage 2: low result, low carry and the high operand halves.
  logic         r_v2;
  logic [N-1:0] r_lo2;
  logic         r_c2;
  logic [N-1:0] r_ah2;
  logic [N-1:0] r_bh2;

  // Stage 3: final result and flags.
  logic         r_v3;
  logic [M-1:0] r_d3;
  logic         r_bor3;
  logic         r_ovf3;
  logic         r_zero3;

  logic         w_adv1;
  logic         w_adv2;
  logic         w_adv3;
  logic         w_accept;

  logic [N-1:0] w_lo_sum;
  logic         w_lo_cout;
  logic [N-1:0] w_hi_sum;
  logic         w_hi_cout;
  logic [M-1:0] w_d;
  logic         w_ovf;

  // A stage may load when it is empty or the stage after it is moving.
  assign w_adv3   = ~r_v3 | ready_i;
  assign w_adv2   = ~r_v2 | w_adv3;
  assign w_adv1   = ~r_v1 | w_adv2;
  assign ready_o  = w_adv1 & ~rst_i;
  assign w_accept = valid_i & ready_o;

  // Low half: a_lo + ~b_lo + ~bor_i.
  adderNbit #(.N(N)) u_add_lo (
    .i_a    (r_a1[N-1:0]),
    .i_b    (~r_b1[N-1:0]),
    .i_cin  (~r_bor1),
    .o_sum  (w_lo_sum),
    .o_cout (w_lo_cout)
  );

  // High half: a_hi + ~b_hi + registered low carry.
  adderNbit #(.N(N)) u_add_hi (
    .i_a    (r_ah2),
    .i_b    (~r_bh2),
    .i_cin  (r_c2),
    .o_sum  (w_hi_sum),
    .o_cout (w_hi_cout)
  );

  assign w_d   = {w_hi_sum, r_lo2};
  // Signed overflow: operand signs differ and the result sign differs from a.
  assign w_ovf = (r_ah2[N-1] != r_bh2[N-1]) && (w_hi_sum[N-1] != r_ah2[N-1]);

  // Stage 1 register: capture an accepted operand set.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every stage samples the
    // pre-edge value of the stage before it, giving a true pipeline.
    if (rst_i) begin
      // NOTE: data registers are cleared along with the valid bits so the
      // whole pipe starts from a known all-zero state after reset.
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_bor1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a1   <= a_i;
        r_b1   <= b_i;
        r_bor1 <= bor_i;
      end
    end
  end

  // Stage 2 register: low-half result, its carry and the high operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v2  <= 1'b0;
      r_lo2 <= '0;
      r_c2  <= 1'b0;
      r_ah2 <= '0;
      r_bh2 <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_lo2 <= w_lo_sum;
        r_c2  <= w_lo_cout;
        r_ah2 <= r_a1[M-1:N];
        r_bh2 <= r_b1[M-1:N];
      end
    end
  end

  // Stage 3 register: full difference and flags, held while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v3    <= 1'b0;
      r_d3    <= '0;
      r_bor3  <= 1'b0;
      r_ovf3  <= 1'b0;
      r_zero3 <= 1'b0;
    end else if (w_adv3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_d3    <= w_d;
        r_bor3  <= ~w_hi_cout;
        r_ovf3  <= w_ovf;
        r_zero3 <= ~|w_d;
      end
    end
  end

  assign valid_o = r_v3;
  assign d_o     = r_d3;
  assign bor_o   = r_bor3;
  assign ovf_o   = r_ovf3;
  assign zero_o  = r_zero3;

endmodule : sub2etapas_hs

// File: tb/tb_sub2etapas_hs.sv
// Self-checking bench for sub2etapas_hs: directed vectors, stall/backpressure,
// random traffic against a scoreboard, and reset while operands are in flight.
module tb_sub2etapas_hs;

  logic        clk_i;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        bor_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] d_o;
  logic        bor_o;
  logic        ovf_o;
  logic        zero_o;

  sub2etapas_hs dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .a_i     (a_i),
    .b_i     (b_i),
    .bor_i   (bor_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .d_o     (d_o),
    .bor_o   (bor_o),
    .ovf_o   (ovf_o),
    .zero_o  (zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic        bor;
    logic        ovf;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t nxt;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop = -1;
  bit   chk_lat = 1'b0;
  bit   chk_consec = 1'b0;
  bit   acc;
  logic last_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 33-bit subtraction; bit 32 is the borrow.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bor);
    logic [32:0] t;
    exp_t        e;
    t      = {1'b0, a} - {1'b0, b} - {32'd0, bor};
    e.d    = t[31:0];
    e.bor  = t[32];
    e.ovf  = (a[31] != b[31]) && (e.d[31] != a[31]);
    e.zero = (e.d == 32'd0);
    e.cyc  = 0;
    return e;
  endfunction

  // One clock: observe at the falling edge, then let the rising edge happen.
  task automatic step();
    exp_t e;
    @(negedge clk_i);
    last_ready = ready_o;
    acc = 1'b0;
    if (!rst_i) begin
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", valid_o, 0);
        end else begin
          e = sb.pop_front();
          check("out_d", d_o, e.d);
          check("out_bor", bor_o, e.bor);
          check("out_ovf", ovf_o, e.ovf);
          check("out_zero", zero_o, e.zero);
          if (chk_lat) check("latency", cyc - e.cyc, 3);
          if (chk_consec && last_pop >= 0) check("consecutive", cyc - last_pop, 1);
          last_pop = cyc;
        end
      end else if (valid_o && !ready_i && sb.size() > 0) begin
        check("held_d", d_o, sb[0].d);
      end
      if (valid_i && ready_o) begin
        e     = nxt;
        e.cyc = cyc;
        sb.push_back(e);
        acc = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    if (rst_i) sb.delete();
  endtask

  task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic bor, input exp_t e);
    a_i   = a;
    b_i   = b;
    bor_i = bor;
    nxt   = e;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic bor,
                         input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
    exp_t e;
    int   k;
    e.d = ed; e.bor = eb; e.ovf = eo; e.zero = ez; e.cyc = 0;
    set_op(a, b, bor, e);
    valid_i = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!acc && k < 20);
    valid_i = 1'b0;
    check("accept_in_time", acc, 1);
  endtask

  task automatic drain(input string tag);
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) step();
    check(tag, sb.size(), 0);
  endtask

  initial begin
    logic [31:0] st_a [4];
    logic [31:0] st_b [4];
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rbor;
    int          idx;

    st_a = '{32'd10, 32'd20, 32'd30, 32'd40};
    st_b = '{32'd1, 32'd2, 32'd3, 32'd4};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; bor_i = 1'b0;

    // Reset state.
    step();
    check("ready_in_reset", last_ready, 0);
    step();
    check("rst_valid", valid_o, 0);
    check("rst_d", d_o, 0);
    check("rst_bor", bor_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_zero", zero_o, 0);
    rst_i = 1'b0;
    step();
    check("ready_after_reset", last_ready, 1);

    // Directed vectors, back to back, no stall.
    ready_i = 1'b1;
    chk_lat = 1'b1;
    send_op(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    send_op(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
    send_op(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_op(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_op(32'h0000_0007, 32'h0000_0007, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_op(32'h0000_0007, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    drain("directed_drained");
    chk_lat = 1'b0;

    // Stall: four back-to-back ops with the output blocked for six cycles.
    ready_i = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      if (idx < 4) begin
        set_op(st_a[idx], st_b[idx], 1'b0, model(st_a[idx], st_b[idx], 1'b0));
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      step();
      if (acc) idx++;
      if (c == 3) check("stall_ready_low", last_ready, 0);
    end
    check("stall_fourth_waits", idx, 3);
    check("stall_held_valid", valid_o, 1);
    check("stall_held_d", d_o, 32'd9);
    ready_i = 1'b1;
    chk_consec = 1'b1;
    last_pop = -1;
    for (int c = 0; c < 20 && (idx < 4 || sb.size() > 0); c++) begin
      if (idx < 4) begin
        set_op(st_a[idx], st_b[idx], 1'b0, model(st_a[idx], st_b[idx], 1'b0));
        valid_i = 1'b1;
      end else begin
        valid_i = 1'b0;
      end
      step();
      if (acc) idx++;
    end
    valid_i = 1'b0;
    chk_consec = 1'b0;
    check("stall_all_sent", idx, 4);
    check("stall_drained", sb.size(), 0);

    // Random traffic with random valid_i and ready_i.
    for (int c = 0; c < 1000; c++) begin
      ra   = $urandom;
      rb   = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rbor = 1'($urandom_range(0, 1));
      set_op(ra, rb, rbor, model(ra, rb, rbor));
      valid_i = ($urandom_range(0, 9) < 7);
      ready_i = ($urandom_range(0, 9) < 7);
      step();
    end
    drain("random_drained");

    // Reset with two operands in flight.
    ready_i = 1'b1;
    send_op(32'd100, 32'd1, 1'b0, 32'd99, 1'b0, 1'b0, 1'b0);
    send_op(32'd200, 32'd2, 1'b0, 32'd198, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_valid", valid_o, 0);
    check("midrst_d", d_o, 0);
    check("midrst_bor", bor_o, 0);
    check("midrst_ovf", ovf_o, 0);
    check("midrst_zero", zero_o, 0);
    step();
    check("midrst_ready", last_ready, 1);
    for (int c = 0; c < 6; c++) step();
    check("midrst_no_stale", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_sub2etapas_hs
